// File: rtl/switch_irq_pkg.sv
// Shared constants for the switch/LED Avalon slave: register addresses and CTRL layout.
package switch_irq_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE = 3'd2;
    localparam logic [2:0] ADDR_LED  = 3'd3;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    localparam logic [1:0] CTRL_RESET    = 2'b11;
    localparam int         CTRL_RISE_BIT = 0;
    localparam int         CTRL_FALL_BIT = 1;

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-FF synchroniser followed by a stability counter that
// only accepts a new level after it has held for DEBOUNCE_CYCLES clocks.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic stable
);

    logic             sync1_q, sync1_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        sync1_d  = sw_in;
        sync_d   = sync1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_irq_ctrl.sv
// Avalon-MM switch/LED slave: debounced switch inputs, per-bit edge capture
// with mask, level irq to the HPS, and an LED output register.
module switch_irq_ctrl
    import switch_irq_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] switches_export,
    output logic [WIDTH-1:0] leds_export
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, edge_set, edge_clr;
    logic             unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .sw_in (switches_export[g]),
            .stable(stable[g])
        );
    end

    // Bus handshake: no waitrequest, so every strobe is accepted on the edge it
    // is sampled; a read returns on the following cycle from pre-write state.
    always_comb begin
        stable_prev_d = stable;
        mask_d        = mask_q;
        led_d         = led_q;
        ctrl_d        = ctrl_q;
        edge_clr      = '0;
        rise          = stable & ~stable_prev_q;
        fall          = ~stable & stable_prev_q;
        edge_set      = (rise & {WIDTH{ctrl_q[CTRL_RISE_BIT]}})
                      | (fall & {WIDTH{ctrl_q[CTRL_FALL_BIT]}});
        if (avs_write) begin
            case (avs_address)
                ADDR_MASK: mask_d   = avs_writedata[WIDTH-1:0];
                ADDR_EDGE: edge_clr = avs_writedata[WIDTH-1:0];
                ADDR_LED:  led_d    = avs_writedata[WIDTH-1:0];
                ADDR_CTRL: ctrl_d   = avs_writedata[1:0];
                default:   ;
            endcase
        end
        // A new edge beats a simultaneous W1C so no event is ever lost.
        edge_d = (edge_q & ~edge_clr) | edge_set;
        irq_d  = |(edge_q & mask_q);

        readdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
                ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
                ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
                ADDR_LED:  readdata_d[WIDTH-1:0] = led_q;
                ADDR_CTRL: readdata_d[1:0]       = ctrl_q;
                default:   readdata_d            = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable_prev_q <= '0;
            mask_q        <= '0;
            edge_q        <= '0;
            led_q         <= '0;
            ctrl_q        <= CTRL_RESET;
            irq_q         <= 1'b0;
            readdata_q    <= '0;
        end else begin
            stable_prev_q <= stable_prev_d;
            mask_q        <= mask_d;
            edge_q        <= edge_d;
            led_q         <= led_d;
            ctrl_q        <= ctrl_d;
            irq_q         <= irq_d;
            readdata_q    <= readdata_d;
        end
    end

    assign unused_wdata = ^avs_writedata;
    assign avs_readdata = readdata_q;
    assign irq          = irq_q;
    assign leds_export  = led_q;

endmodule

// File: tb/tb_switch_irq_ctrl.sv
// Bench for switch_irq_ctrl: reset readback table, directed corner sequences
// and randomized bus/switch traffic checked against an event-level model.
module tb_switch_irq_ctrl;

    localparam int W  = 4;
    localparam int DB = 8;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [W-1:0] switches_export = '0;
    logic [W-1:0] leds_export;

    always #5 clk_clk = ~clk_clk;

    switch_irq_ctrl #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .irq            (irq),
        .switches_export(switches_export),
        .leds_export    (leds_export)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Switch levels reach the debouncer two edges late; a level is accepted once it
    // has disagreed with the accepted value on DB consecutive edges. Accepted-level
    // changes become EDGE bits one edge later, and irq follows EDGE&MASK one edge later.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_stable, m_pend_rise, m_pend_fall, m_mask, m_edge, m_led;
    logic [1:0]   m_ctrl;
    logic         m_irq;
    int           m_since[W];
    int           m_edge_no;

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_stable = '0; m_pend_rise = '0; m_pend_fall = '0;
        m_mask = '0; m_edge = '0; m_led = '0; m_ctrl = 2'b11; m_irq = 1'b0;
        for (int i = 0; i < W; i++) m_since[i] = -1;
        m_edge_no = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v[W-1:0] = m_stable;
            3'd1: v[W-1:0] = m_mask;
            3'd2: v[W-1:0] = m_edge;
            3'd3: v[W-1:0] = m_led;
            3'd4: v[1:0]   = m_ctrl;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        logic [W-1:0] clr, new_edge, sync, rise, fall;
        logic         new_irq;
        if (avs_read) exp_q.push_back(model_reg(avs_address));
        new_irq  = |(m_edge & m_mask);
        clr      = (avs_write && avs_address == 3'd2) ? avs_writedata[W-1:0] : '0;
        new_edge = (m_edge & ~clr) | (m_pend_rise & {W{m_ctrl[0]}}) | (m_pend_fall & {W{m_ctrl[1]}});
        sync = m_pipe[0];
        rise = '0;
        fall = '0;
        for (int i = 0; i < W; i++) begin
            if (sync[i] != m_stable[i]) begin
                if (m_since[i] < 0) m_since[i] = m_edge_no;
                if (m_edge_no - m_since[i] + 1 == DB) begin
                    m_stable[i] = sync[i];
                    rise[i] = sync[i];
                    fall[i] = ~sync[i];
                    m_since[i] = -1;
                end
            end else begin
                m_since[i] = -1;
            end
        end
        if (avs_write) begin
            case (avs_address)
                3'd1: m_mask = avs_writedata[W-1:0];
                3'd3: m_led  = avs_writedata[W-1:0];
                3'd4: m_ctrl = avs_writedata[1:0];
                default: ;
            endcase
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(switches_export);
        m_pend_rise = rise;
        m_pend_fall = fall;
        m_edge = new_edge;
        m_irq  = new_irq;
        m_edge_no++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_edge();
        @(posedge clk_clk);
        @(negedge clk_clk);
        if (exp_q.size() > 0) check("readdata_model", avs_readdata, exp_q.pop_front());
        check("irq_model", 32'(irq), 32'(m_irq));
        check("leds_model", 32'(leds_export), 32'(m_led));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // ---------------- reset readback table ----------------
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic [W-1:0] exp_led;
    } vec_t;
    vec_t reset_tbl[8];

    task automatic check_reset_table(input string tag);
        logic [31:0] rd;
        foreach (reset_tbl[i]) begin
            bus_read(reset_tbl[i].addr, rd);
            check({tag, "_rd"}, rd, reset_tbl[i].exp_rd);
            check({tag, "_irq"}, 32'(irq), 32'(reset_tbl[i].exp_irq));
            check({tag, "_leds"}, 32'(leds_export), 32'(reset_tbl[i].exp_led));
        end
    endtask

    initial begin
        logic [31:0] rd;
        int op, idx;

        for (int i = 0; i < 8; i++) begin
            reset_tbl[i].addr    = 3'(i);
            reset_tbl[i].exp_rd  = (i == 4) ? 32'd3 : 32'd0;
            reset_tbl[i].exp_irq = 1'b0;
            reset_tbl[i].exp_led = '0;
        end

        // 1. reset readback
        model_reset();
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        check_reset_table("reset");

        // 2. clean rising step on sw[0] with MASK=1
        bus_write(3'd1, 32'h1);
        avs_address = 3'd0;
        avs_read = 1'b1;
        switches_export[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("data_step", avs_readdata, (k >= 11) ? 32'd1 : 32'd0);
            check("irq_step", 32'(irq), (k >= 12) ? 32'd1 : 32'd0);
        end
        avs_read = 1'b0;
        bus_read(3'd2, rd);
        check("edge_after_step", rd, 32'h1);
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, rd);
        check("edge_after_w1c", rd, 32'h0);
        check("irq_after_w1c", 32'(irq), 32'd0);

        // 3. glitch shorter than the debounce window
        switches_export[2] = 1'b1;
        run(5);
        switches_export[2] = 1'b0;
        run(20);
        bus_read(3'd0, rd);
        check("data_glitch", rd, 32'h1);
        bus_read(3'd2, rd);
        check("edge_glitch", rd, 32'h0);
        check("irq_glitch", 32'(irq), 32'd0);

        // 4. CTRL edge selection on sw[1]
        switches_export[1] = 1'b1;
        run(12);
        bus_write(3'd2, 32'hF);
        bus_write(3'd4, 32'h1);
        switches_export[1] = 1'b0;
        run(12);
        bus_read(3'd2, rd);
        check("edge_fall_rise_only", rd, 32'h0);
        bus_write(3'd4, 32'h2);
        switches_export[1] = 1'b1;
        run(12);
        bus_read(3'd2, rd);
        check("edge_rise_fall_only", rd, 32'h0);
        switches_export[1] = 1'b0;
        run(12);
        bus_read(3'd2, rd);
        check("edge_fall_captured", rd, 32'h2);
        bus_write(3'd2, 32'hF);

        // 5. W1C coincident with a new bit-3 edge, irq masked
        bus_write(3'd4, 32'h3);
        bus_write(3'd1, 32'h0);
        switches_export[3] = 1'b1;
        run(10);
        bus_write(3'd2, 32'h8);
        bus_read(3'd2, rd);
        check("edge_set_wins", rd, 32'h8);
        check("irq_masked", 32'(irq), 32'd0);
        run(4);
        check("irq_masked_hold", 32'(irq), 32'd0);

        // 6. LED register, then reset in the middle of a debounce
        bus_write(3'd3, 32'hA);
        check("leds_write", 32'(leds_export), 32'hA);
        bus_read(3'd3, rd);
        check("led_readback", rd, 32'hA);
        bus_write(3'd1, 32'hF);
        switches_export = '0;
        run(5);
        reset_reset_n = 1'b0;
        #1;
        check("async_rst_rd", avs_readdata, 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_leds", 32'(leds_export), 32'd0);
        model_reset();
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        check_reset_table("midreset");
        run(20);
        bus_read(3'd2, rd);
        check("edge_after_midreset", rd, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                idx = $urandom_range(0, W - 1);
                switches_export[idx] = ~switches_export[idx];
            end
            op = $urandom_range(0, 5);
            avs_address   = 3'($urandom_range(0, 7));
            avs_writedata = $urandom;
            avs_read  = (op == 0 || op == 2);
            avs_write = (op == 1 || op == 2);
            tick();
            avs_read  = 1'b0;
            avs_write = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
